// File: rtl/edge_pulse_bank.sv
// Multi-channel edge-to-pulse converter: each channel synchronises a slow level
// input, debounces it, and emits a one-cycle strobe plus a sticky event flag.
module edge_pulse_bank #(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic [CHANNELS-1:0]   sig_in,
    input  logic [2*CHANNELS-1:0] mode,
    input  logic [CHANNELS-1:0]   event_clr,
    output logic [CHANNELS-1:0]   pulse_out,
    output logic [CHANNELS-1:0]   level_out,
    output logic [CHANNELS-1:0]   event_pending
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s;
        logic                   lvl_q, lvl_d;
        logic [CNT_W-1:0]       cnt_q, cnt_d;
        logic                   pulse_q, pulse_d;
        logic                   pend_q, pend_d;
        logic                   update;

        assign s = sync_q[SYNC_STAGES-1];

        always_comb begin
            lvl_d  = lvl_q;
            cnt_d  = '0;
            update = 1'b0;
            if (s != lvl_q) begin
                if (cnt_q == CNT_LAST) begin
                    lvl_d  = s;
                    update = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // The new level decides the direction: 1 = rising (bit 0), 0 = falling (bit 1).
            pulse_d = update & (s ? mode[2*gi] : mode[2*gi+1]);
            pend_d  = pulse_d | (pend_q & ~event_clr[gi]);
        end

        always_ff @(posedge clk or posedge RST) begin
            if (RST) begin
                sync_q  <= '0;
                lvl_q   <= 1'b0;
                cnt_q   <= '0;
                pulse_q <= 1'b0;
                pend_q  <= 1'b0;
            end else begin
                sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_in[gi]};
                lvl_q   <= lvl_d;
                cnt_q   <= cnt_d;
                pulse_q <= pulse_d;
                pend_q  <= pend_d;
            end
        end

        assign pulse_out[gi]     = pulse_q;
        assign level_out[gi]     = lvl_q;
        assign event_pending[gi] = pend_q;
    end

endmodule
